pedge_event_arbiter: RTL

Round-robin event scheduler downstream of the per-bit positive-edge detector. It captures single-cycle `pedge` pulses from N independent inputs into a pending vector. It serializes them to one consumer over a valid/ready handshake, one event index at a time. It flags events lost because their bit was still pending.

---
 rtl/pedge_event_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/pedge_event_arbiter.sv
// Round-robin scheduler: latches edge-detector pulses into a pending vector and
// hands them to one consumer over valid/ready, one index at a time, flagging lost events.
module pedge_event_arbiter #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            arstn,
    input  logic [N-1:0]    pedge,
    output logic            evt_valid,
    output logic [IDXW-1:0] evt_idx,
    input  logic            evt_ready,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    ovf,
    input  logic            ovf_clr
);

    typedef enum logic {IDLE, OFFER} state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
    localparam logic [IDXW:0]   N_EXT    = (IDXW + 1)'(N);

    state_t          state_q, state_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [N-1:0]    ovf_q, ovf_d;
    logic            evt_valid_q, evt_valid_d;
    logic [IDXW-1:0] evt_idx_q, evt_idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

    logic            handshake;
    logic [N-1:0]    served;
    logic            sel_found;
    logic [IDXW-1:0] sel_idx;

    assign handshake = evt_valid_q && evt_ready;

    for (genvar gi = 0; gi < N; gi++) begin : g_served
        assign served[gi] = handshake && (evt_idx_q == IDXW'(gi));
    end

    // Scan downward so the closest set bit at or after ptr is written last and wins.
    always_comb begin
        logic [IDXW:0] cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (IDXW + 1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (pending_q[cand[IDXW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDXW-1:0];
            end
        end
    end

    // A pulse on the bit being served re-arms it rather than counting as lost.
    always_comb begin
        pending_d = (pending_q & ~served) | pedge;
        ovf_d     = (ovf_clr ? '0 : ovf_q) | (pedge & pending_q & ~served);
    end

    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_idx_d   = evt_idx_q;
        ptr_d       = ptr_q;
        case (state_q)
            IDLE: begin
                evt_valid_d = 1'b0;
                if (sel_found) begin
                    evt_idx_d   = sel_idx;
                    evt_valid_d = 1'b1;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    ptr_d       = (evt_idx_q == LAST_IDX) ? '0 : evt_idx_q + 1'b1;
                    evt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                evt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            ovf_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            evt_valid_q <= evt_valid_d;
            evt_idx_q   <= evt_idx_d;
            ptr_q       <= ptr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_idx   = evt_idx_q;
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule
